// File: rtl/dcp_dump_if.sv
// Memory read port and UART transmit byte stream shared by the dump engine.
// master = dump engine, slave = memory/transmitter side.
interface dcp_dump_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [DATA_W-1:0] mem_rdata;
   logic [7:0]        d_tx;
   logic              vld_tx;
   logic              rdy_tx;

   modport master (
      output mem_addr, mem_rd, d_tx, vld_tx,
      input  mem_rdata, rdy_tx
   );

   modport slave (
      input  mem_addr, mem_rd, d_tx, vld_tx,
      output mem_rdata, rdy_tx
   );
endinterface

// File: rtl/dcp_dump.sv
// Memory dump engine for the debug unit's D command: reads a block of words
// and streams them as "AAAAAAAA: DDDDDDDD ..." CR LF lines, one byte per handshake.
module dcp_dump #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int LINES          = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              use_new,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] end_addr,
   output logic              busy,
   output logic              finish,
   dcp_dump_if.master        bus
);
   localparam int ADDR_NIB = ADDR_W / 4;
   localparam int DATA_NIB = DATA_W / 4;
   localparam int MAX_NIB  = (ADDR_NIB > DATA_NIB) ? ADDR_NIB : DATA_NIB;
   localparam int NW       = $clog2(MAX_NIB) + 1;
   localparam int WW       = $clog2(WORDS_PER_LINE) + 1;
   localparam int LW       = $clog2(LINES) + 1;

   localparam logic [NW-1:0] ADDR_LAST = NW'(ADDR_NIB - 1);
   localparam logic [NW-1:0] DATA_LAST = NW'(DATA_NIB - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_LINE - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);

   typedef enum logic [3:0] {
      IDLE, PADDR, PCOLON, PSPC, READ, WAIT, PDATA, PSEP, PCR, PLF, DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] cur_reg, cur_next;
   logic [DATA_W-1:0] data_reg, data_next;
   logic [NW-1:0]     nib_reg, nib_next;
   logic [WW-1:0]     word_reg, word_next;
   logic [LW-1:0]     line_reg, line_next;
   logic [ADDR_W-1:0] end_addr_reg, end_addr_next;

   logic [ADDR_W-1:0] addr_sh;
   logic [DATA_W-1:0] data_sh;
   logic [7:0]        d_tx_c;
   logic              vld_tx_c;
   logic              mem_rd_c;
   logic [ADDR_W-1:0] mem_addr_c;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         cur_reg      <= '0;
         data_reg     <= '0;
         nib_reg      <= '0;
         word_reg     <= '0;
         line_reg     <= '0;
         end_addr_reg <= '0;
      end else begin
         state_reg    <= state_next;
         cur_reg      <= cur_next;
         data_reg     <= data_next;
         nib_reg      <= nib_next;
         word_reg     <= word_next;
         line_reg     <= line_next;
         end_addr_reg <= end_addr_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cur_next      = cur_reg;
      data_next     = data_reg;
      nib_next      = nib_reg;
      word_next     = word_reg;
      line_next     = line_reg;
      end_addr_next = end_addr_reg;
      d_tx_c        = 8'h00;
      vld_tx_c      = 1'b0;
      mem_rd_c      = 1'b0;
      mem_addr_c    = '0;
      // nib_reg indexes the digit being shown, counting down from the MSB nibble
      addr_sh       = cur_reg >> {nib_reg, 2'b00};
      data_sh       = data_reg >> {nib_reg, 2'b00};

      case (state_reg)
         IDLE: begin
            if (we) begin
               cur_next   = use_new ? start_addr : last_addr + ADDR_W'(1);
               word_next  = '0;
               line_next  = '0;
               nib_next   = ADDR_LAST;
               state_next = PADDR;
            end
         end
         PADDR: begin
            vld_tx_c = 1'b1;
            d_tx_c   = hex_char(addr_sh[3:0]);
            if (bus.rdy_tx) begin
               if (nib_reg == '0) state_next = PCOLON;
               else               nib_next   = nib_reg - NW'(1);
            end
         end
         PCOLON: begin
            vld_tx_c = 1'b1;
            d_tx_c   = 8'h3A;
            if (bus.rdy_tx) state_next = PSPC;
         end
         PSPC: begin
            vld_tx_c = 1'b1;
            d_tx_c   = 8'h20;
            if (bus.rdy_tx) state_next = READ;
         end
         READ: begin
            mem_rd_c   = 1'b1;
            mem_addr_c = cur_reg;
            state_next = WAIT;
         end
         WAIT: begin
            data_next  = bus.mem_rdata;
            nib_next   = DATA_LAST;
            state_next = PDATA;
         end
         PDATA: begin
            vld_tx_c = 1'b1;
            d_tx_c   = hex_char(data_sh[3:0]);
            if (bus.rdy_tx) begin
               if (nib_reg != '0) begin
                  nib_next = nib_reg - NW'(1);
               end else if (word_reg != WORD_LAST) begin
                  cur_next   = cur_reg + ADDR_W'(1);
                  word_next  = word_reg + WW'(1);
                  state_next = PSEP;
               end else begin
                  state_next = PCR;
               end
            end
         end
         PSEP: begin
            vld_tx_c = 1'b1;
            d_tx_c   = 8'h20;
            if (bus.rdy_tx) state_next = READ;
         end
         PCR: begin
            vld_tx_c = 1'b1;
            d_tx_c   = 8'h0D;
            if (bus.rdy_tx) state_next = PLF;
         end
         PLF: begin
            vld_tx_c = 1'b1;
            d_tx_c   = 8'h0A;
            if (bus.rdy_tx) begin
               if (line_reg != LINE_LAST) begin
                  cur_next   = cur_reg + ADDR_W'(1);
                  line_next  = line_reg + LW'(1);
                  word_next  = '0;
                  nib_next   = ADDR_LAST;
                  state_next = PADDR;
               end else begin
                  end_addr_next = cur_reg;
                  state_next    = DONE;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.d_tx     = d_tx_c;
   assign bus.vld_tx   = vld_tx_c;
   assign bus.mem_rd   = mem_rd_c;
   assign bus.mem_addr = mem_addr_c;
   assign end_addr     = end_addr_reg;
   assign busy         = (state_reg != IDLE) && (state_reg != DONE);
   assign finish       = (state_reg == DONE);
endmodule

// File: tb/tb_dcp_dump.sv
// Directed bench for dcp_dump: default-parameter instance plus a small
// 16-bit address / 8-bit data instance.
module tb_dcp_dump;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, we, use_new, busy, finish;
   logic [31:0] start_addr, last_addr, end_addr;
   logic        we2, busy2, finish2;
   logic [15:0] start_addr2, end_addr2;

   dcp_dump_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   dcp_dump_if #(.ADDR_W(16), .DATA_W(8))  bus2 ();

   dcp_dump dut (
      .clk(clk), .rst(rst), .we(we), .use_new(use_new),
      .start_addr(start_addr), .last_addr(last_addr), .end_addr(end_addr),
      .busy(busy), .finish(finish), .bus(bus)
   );

   dcp_dump #(.ADDR_W(16), .DATA_W(8), .WORDS_PER_LINE(1), .LINES(2)) dut2 (
      .clk(clk), .rst(rst), .we(we2), .use_new(1'b1),
      .start_addr(start_addr2), .last_addr(16'h0000), .end_addr(end_addr2),
      .busy(busy2), .finish(finish2), .bus(bus2)
   );

   // Memory models: data only valid the cycle after the read strobe
   always @(posedge clk) begin
      bus.mem_rdata  <= bus.mem_rd  ? (32'hA000_0000 + bus.mem_addr) : 32'hDEAD_BEEF;
      bus2.mem_rdata <= bus2.mem_rd ? 8'h5A : 8'hEE;
   end

   logic [7:0] cap [0:4095];
   logic [7:0] cap2 [0:63];
   int cap_n = 0, cap2_n = 0, rd_n = 0, fin_n = 0, stall_bad = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_d = 8'h00;

   always @(posedge clk) begin
      if (!rst) begin
         if (bus.vld_tx && bus.rdy_tx) begin
            cap[cap_n] <= bus.d_tx;
            cap_n      <= cap_n + 1;
         end
         if (bus.mem_rd) rd_n <= rd_n + 1;
         if (finish) fin_n <= fin_n + 1;
         if (prev_stall && (!bus.vld_tx || bus.d_tx !== prev_d)) stall_bad <= stall_bad + 1;
         prev_stall <= bus.vld_tx && !bus.rdy_tx;
         prev_d     <= bus.d_tx;
         if (bus2.vld_tx && bus2.rdy_tx) begin
            cap2[cap2_n] <= bus2.d_tx;
            cap2_n       <= cap2_n + 1;
         end
      end else begin
         prev_stall <= 1'b0;
      end
   end

   int n_assert = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_line(input string tag, input int base, input string exp);
      string s;
      s = "";
      for (int i = 0; i < exp.len(); i++) s = $sformatf("%s%c", s, cap[base + i]);
      n_assert++;
      assert (s == exp) else begin
         n_fail++;
         $error("FAIL %s: got '%s' expected '%s'", tag, s, exp);
      end
      chk({tag, "_cr"}, 64'(cap[base + exp.len()]), 64'h0D);
      chk({tag, "_lf"}, 64'(cap[base + exp.len() + 1]), 64'h0A);
   endtask

   task automatic start_cmd(input logic un, input logic [31:0] sa, input logic [31:0] la);
      @(negedge clk);
      we = 1'b1; use_new = un; start_addr = sa; last_addr = la;
      @(negedge clk);
      we = 1'b0;
   endtask

   // Waits on negedges for finish; rand_rdy throttles the transmitter to ~30%
   task automatic wait_finish(input int budget, input bit rand_rdy);
      int n;
      n = 0;
      while (!finish && n < budget) begin
         if (rand_rdy) bus.rdy_tx = ($urandom_range(0, 9) < 3);
         @(negedge clk);
         n++;
      end
      chk("finish_timeout", 64'(n >= budget), 64'h0);
   endtask

   int base, rd0, fin0, mism;
   logic [7:0] ref_stream [0:375];

   initial begin
      rst = 1'b1; we = 1'b0; use_new = 1'b0; start_addr = '0; last_addr = '0;
      we2 = 1'b0; start_addr2 = '0;
      bus.rdy_tx = 1'b1; bus2.rdy_tx = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_vld",      64'(bus.vld_tx),   64'h0);
      chk("rst_dtx",      64'(bus.d_tx),     64'h0);
      chk("rst_busy",     64'(busy),         64'h0);
      chk("rst_finish",   64'(finish),       64'h0);
      chk("rst_mem_rd",   64'(bus.mem_rd),   64'h0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
      chk("rst_end_addr", 64'(end_addr),     64'h0);
      rst = 1'b0;

      // Command 1: explicit start, transmitter always ready
      base = cap_n; rd0 = rd_n; fin0 = fin_n;
      start_cmd(1'b1, 32'h0000_0010, 32'h0);
      chk("first_busy", 64'(busy),        64'h1);
      chk("first_vld",  64'(bus.vld_tx),  64'h1);
      chk("first_dtx",  64'(bus.d_tx),    64'h30);
      wait_finish(2000, 1'b0);
      chk("c1_end_addr", 64'(end_addr), 64'h2F);
      chk("c1_busy_at_done", 64'(busy), 64'h0);
      @(negedge clk);
      chk("c1_finish_pulse", 64'(finish), 64'h0);
      chk("c1_bytes", 64'(cap_n - base), 64'd376);
      chk("c1_reads", 64'(rd_n - rd0), 64'd32);
      chk("c1_finishes", 64'(fin_n - fin0), 64'd1);
      chk_line("c1_line1", base, "00000010: A0000010 A0000011 A0000012 A0000013");
      chk_line("c1_line8", base + 7 * 47, "0000002C: A000002C A000002D A000002E A000002F");
      for (int i = 0; i < 376; i++) ref_stream[i] = cap[base + i];

      // Command 2: continue from last_addr, with a stray we pulse while busy
      base = cap_n;
      start_cmd(1'b0, 32'h0, 32'h0000_002F);
      repeat (20) @(negedge clk);
      we = 1'b1; use_new = 1'b1; start_addr = 32'h0000_0500;
      @(negedge clk);
      we = 1'b0;
      wait_finish(2000, 1'b0);
      chk("c2_end_addr", 64'(end_addr), 64'h4F);
      @(negedge clk);
      chk("c2_bytes", 64'(cap_n - base), 64'd376);
      chk_line("c2_line1", base, "00000030: A0000030 A0000031 A0000032 A0000033");

      // Command 3: address wrap
      base = cap_n;
      start_cmd(1'b1, 32'hFFFF_FFFE, 32'h0);
      wait_finish(2000, 1'b0);
      chk("wrap_end_addr", 64'(end_addr), 64'h1D);
      @(negedge clk);
      chk_line("wrap_line1", base, "FFFFFFFE: 9FFFFFFE 9FFFFFFF A0000000 A0000001");
      chk_line("wrap_line2", base + 47, "00000002: A0000002 A0000003 A0000004 A0000005");

      // Command 4: random backpressure must reproduce command 1's stream
      base = cap_n; rd0 = rd_n;
      start_cmd(1'b1, 32'h0000_0010, 32'h0);
      wait_finish(6000, 1'b1);
      bus.rdy_tx = 1'b1;
      @(negedge clk);
      chk("bp_bytes", 64'(cap_n - base), 64'd376);
      mism = 0;
      for (int i = 0; i < 376; i++) if (cap[base + i] !== ref_stream[i]) mism++;
      chk("bp_stream_mismatches", 64'(mism), 64'h0);
      chk("bp_stall_changes", 64'(stall_bad), 64'h0);
      chk("bp_reads", 64'(rd_n - rd0), 64'd32);
      chk("bp_end_addr", 64'(end_addr), 64'h2F);

      // Command 5: reset during the third word of line 2, then restart
      base = cap_n;
      start_cmd(1'b1, 32'h0000_0010, 32'h0);
      for (int n = 0; n < 500 && (cap_n - base) < 47 + 30; n++) @(negedge clk);
      chk("rst_mid_reached", 64'(cap_n - base >= 47 + 30), 64'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_vld",    64'(bus.vld_tx), 64'h0);
      chk("abort_busy",   64'(busy),       64'h0);
      chk("abort_mem_rd", 64'(bus.mem_rd), 64'h0);
      rst = 1'b0;
      base = cap_n;
      start_cmd(1'b1, 32'h0000_0010, 32'h0);
      wait_finish(2000, 1'b0);
      @(negedge clk);
      chk("restart_bytes", 64'(cap_n - base), 64'd376);
      chk_line("restart_line1", base, "00000010: A0000010 A0000011 A0000012 A0000013");

      // Small parameter set
      @(negedge clk);
      we2 = 1'b1; start_addr2 = 16'h1234;
      @(negedge clk);
      we2 = 1'b0;
      for (int n = 0; n < 200 && !finish2; n++) @(negedge clk);
      chk("p2_finish", 64'(finish2), 64'h1);
      chk("p2_end_addr", 64'(end_addr2), 64'h1235);
      @(negedge clk);
      chk("p2_bytes", 64'(cap2_n), 64'd20);
      mism = 0;
      begin
         string exp2;
         exp2 = "1234: 5A  1235: 5A  ";
         for (int i = 0; i < 20; i++) begin
            if (i == 8 || i == 18) begin
               if (cap2[i] !== 8'h0D) mism++;
            end else if (i == 9 || i == 19) begin
               if (cap2[i] !== 8'h0A) mism++;
            end else if (cap2[i] !== 8'(exp2[i])) begin
               mism++;
            end
         end
      end
      chk("p2_stream_mismatches", 64'(mism), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/dcp_dump.md
# dcp_dump

Parametrised memory-dump engine for the serial debug unit's D command. On a start request it reads a block of memory words through a synchronous read port and streams them to the UART transmit path as ASCII hex lines, one byte per ready/valid handshake. Each line is `AAAAAAAA: DDDDDDDD DDDDDDDD ...` followed by CR LF. The block reports the last address dumped, so the next D command with no address continues where this one stopped.

## Interface
- ADDR_W, 32, memory word-address width; multiple of 4.
- DATA_W, 32, memory word width; multiple of 4.
- WORDS_PER_LINE, 4, words printed per line; ≥1.
- LINES, 8, lines per command; ≥1.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- we  in  1  start request; sampled only in IDLE.
- use_new  in  1  sampled with we: 1 = start at start_addr; 0 = start at last_addr+1.
- start_addr  in  ADDR_W  explicit start address.
- last_addr  in  ADDR_W  last address dumped by the previous command.
- end_addr  out  ADDR_W  last address dumped by this command; registered.
- busy  out  1  high from the cycle after accepted we until finish.
- finish  out  1  one-cycle pulse when the command completes.
- mem_addr  out  ADDR_W  read address.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd.
- d_tx  out  8  ASCII byte to the transmitter.
- vld_tx  out  1  d_tx valid.
- rdy_tx  in  1  transmitter ready; a byte transfers when vld_tx && rdy_tx.

## Operation
- States: IDLE, PADDR, PCOLON, PSPC, READ, WAIT, PDATA, PSEP, PCR, PLF, DONE.
- IDLE, we=1: load cur = use_new ? start_addr : last_addr+1 (mod 2^ADDR_W). Clear the word and line counters. Go to PADDR.
- PADDR: emit ADDR_W/4 hex digits of cur, MSB nibble first, then go to PCOLON.
- PCOLON emits ':' (8'h3A). PSPC emits ' ' (8'h20), then goes to READ.
- READ: mem_rd=1, mem_addr=cur for one cycle. Go to WAIT.
- WAIT: capture mem_rdata into the data shift register. Go to PDATA.
- PDATA: emit DATA_W/4 hex digits, MSB first.
- After the last digit:
  - If it is not the last word of the line: cur <= cur+1, go to PSEP. PSEP emits ' ', then goes to READ.
  - Otherwise: go to PCR.
- PCR emits 8'h0D; PLF emits 8'h0A.
- After PLF:
  - If it is not the last line: cur <= cur+1, go to PADDR.
  - Otherwise: end_addr <= cur, go to DONE.
- DONE: finish=1 for one cycle, busy drops, go to IDLE.
- Hex digits are uppercase ASCII: 0–9 → 8'h30–8'h39, A–F → 8'h41–8'h46.
- Address arithmetic wraps modulo 2^ADDR_W: after FF..FF comes 00..00.
- Bytes per line: ADDR_W/4 + 2 + WORDS_PER_LINE·DATA_W/4 + (WORDS_PER_LINE−1) + 2. With default parameters this is 47 bytes.
- Total words dumped: LINES·WORDS_PER_LINE. end_addr = first address + LINES·WORDS_PER_LINE − 1 (mod 2^ADDR_W).
- we is ignored while busy or in DONE.

## Timing
- Reset values: vld_tx=0, d_tx=8'h00, busy=0, finish=0, mem_rd=0, mem_addr=0, end_addr=0, state IDLE.
- Reset mid-command aborts immediately to reset values; no partial line is completed.
- we accepted at edge T: at T+1 busy=1, vld_tx=1, d_tx = first address digit.
- Emitting states hold vld_tx=1 with d_tx stable until rdy_tx=1. The next byte is presented the following cycle, so with rdy_tx held high there is one byte per cycle.
- vld_tx never drops while a byte is pending.
- READ and WAIT each take exactly one cycle with vld_tx=0. Each word therefore has a 2-cycle gap before its first digit.
- Cycle after the LF transfer of the last line: DONE, finish=1, end_addr already updated.
- IDLE accepts a new we the cycle after DONE.
- rdy_tx held low stalls indefinitely with no state change, no reads and no output change.

## Test plan
- use_new=1, start_addr=0x00000010, memory word n = 0xA0000000+n, rdy_tx=1 → line 1 reads `00000010: A0000010 A0000011 A0000012 A0000013` then CR LF. 8 lines total (376 bytes); end_addr=0x0000002F; one finish pulse.
- Next command with use_new=0, last_addr=0x0000002F → first line begins `00000030:`.
- Wrap: use_new=1, start_addr=0xFFFFFFFE → first line prints addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001; end_addr=0x0000001D.
- Random rdy_tx backpressure (≈30% ready) → byte stream identical to the rdy_tx=1 run; d_tx stable while vld_tx && !rdy_tx; exactly one mem_rd per word, with mem_rdata captured the next cycle.
- Assert rst during word 3 of line 2 → next cycle: vld_tx=0, busy=0, mem_rd=0; a fresh we then restarts from line 1.
- Pulse we while busy → ignored; output stream unchanged. Parameter set DATA_W=8, ADDR_W=16, WORDS_PER_LINE=1, LINES=2 at start 0x1234, data 0x5A → `1234: 5A` CR LF, then `1235: ..` CR LF; end_addr=0x1235.
